reg_scoreboard: RTL

- Hazard controller for the decode stage; tracks in-flight register writes with a per-register pending-write counter.
- Asserts a stall whenever an instruction in ID reads a register that an older, not-yet-written-back instruction will write.
- Sits between the ID stage, which supplies the source/dest fields and issue, and the WB stage, which supplies retirement.
- Replaces the compare-against-EX/MEM-dest hazard logic with a stateful scoreboard plus stall statistics.

---
 rtl/reg_scoreboard_pkg.sv | 13 +
 rtl/reg_scoreboard_if.sv | 36 +++
 rtl/reg_scoreboard_sat_updown_counter.sv | 30 +++
 rtl/reg_scoreboard.sv | 104 ++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register scoreboard.
package reg_scoreboard_pkg;

    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;
    localparam int CNT_W    = 2;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0]  pend_cnt_t;

    localparam pend_cnt_t CNT_MAX = '1;

endpackage

// File: rtl/reg_scoreboard_if.sv
// ID/WB-side bundle of the scoreboard: issue and retire inputs, hazard and status outputs.
interface reg_scoreboard_if #(
    parameter int STALL_CNT_W = 16
);
    import reg_scoreboard_pkg::*;

    logic                         idValid;
    logic                         idUsesRn;
    logic                         idTwoSrc;
    reg_idx_t                     idRn;
    reg_idx_t                     idRdm;
    logic                         idWbEn;
    reg_idx_t                     idDest;
    logic                         idSquash;
    logic                         wbWbEn;
    reg_idx_t                     wbDest;
    logic                         hazard;
    logic [NUM_REGS-1:0]          pendingMask;
    logic                         busy;
    logic                         overflowErr;
    logic                         underflowErr;
    logic [STALL_CNT_W-1:0]       stallCycles;

    modport master (
        output idValid, idUsesRn, idTwoSrc, idRn, idRdm, idWbEn, idDest, idSquash,
        output wbWbEn, wbDest,
        input  hazard, pendingMask, busy, overflowErr, underflowErr, stallCycles
    );

    modport slave (
        input  idValid, idUsesRn, idTwoSrc, idRn, idRdm, idWbEn, idDest, idSquash,
        input  wbWbEn, wbDest,
        output hazard, pendingMask, busy, overflowErr, underflowErr, stallCycles
    );

endinterface

// File: rtl/reg_scoreboard_sat_updown_counter.sv
// Small up/down counter that holds at both limits and pulses when a step is refused.
module sat_updown_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         overflow,
    output logic         underflow
);

    // Simultaneous inc and dec cancel; a lone step moves only when away from the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && !dec && (count != '1)) begin
            count <= count + W'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign overflow  = inc & ~dec & (count == '1);
    assign underflow = dec & ~inc & (count == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage hazard controller: per-register pending-write counts drive the ID stall.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int WB_BYPASS   = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    reg_scoreboard_if.slave bus
);

    pend_cnt_t               counts [NUM_REGS];
    logic [NUM_REGS-1:0]     inc_vec;
    logic [NUM_REGS-1:0]     dec_vec;
    logic [NUM_REGS-1:0]     ovf_vec;
    logic [NUM_REGS-1:0]     unf_vec;
    logic [NUM_REGS-1:0]     hit_vec;
    logic [NUM_REGS-1:0]     pending_mask;
    logic                    hazard;
    logic                    issue;
    logic                    overflow_err;
    logic                    underflow_err;
    logic [STALL_CNT_W-1:0]  stall_cycles;

    // A source is blocked while its count is nonzero, unless the last outstanding
    // write is retiring right now and the register file forwards it through.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            hit_vec[i] = (counts[i] != '0) &&
                         !((WB_BYPASS != 0) && bus.wbWbEn &&
                           (bus.wbDest == reg_idx_t'(i)) && (counts[i] == pend_cnt_t'(1)));
        end
    end

    // Stall and issue decisions use counts from before this cycle's own increment,
    // so an instruction never waits on its own destination.
    always_comb begin
        hazard = bus.idValid & ~bus.idSquash &
                 ((bus.idUsesRn & hit_vec[bus.idRn]) | (bus.idTwoSrc & hit_vec[bus.idRdm]));
        issue  = bus.idValid & ~bus.idSquash & ~hazard & bus.idWbEn;
    end

    // Per-register step requests from issue (ID) and retirement (WB).
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc_vec[i] = issue && (bus.idDest == reg_idx_t'(i));
            dec_vec[i] = bus.wbWbEn && (bus.wbDest == reg_idx_t'(i));
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
        sat_updown_counter #(
            .W (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc_vec[g]),
            .dec       (dec_vec[g]),
            .count     (counts[g]),
            .overflow  (ovf_vec[g]),
            .underflow (unf_vec[g])
        );
    end

    // Pending status reflects registered counts only, with no retire bypass.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pending_mask[i] = (counts[i] != '0);
        end
    end

    // Error flags latch the first refused step and stay up until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (|ovf_vec) overflow_err  <= 1'b1;
            if (|unf_vec) underflow_err <= 1'b1;
        end
    end

    // Stall statistics count hazard cycles and stick at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (hazard && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
        end
    end

    assign bus.hazard       = hazard;
    assign bus.pendingMask  = pending_mask;
    assign bus.busy         = |pending_mask;
    assign bus.overflowErr  = overflow_err;
    assign bus.underflowErr = underflow_err;
    assign bus.stallCycles  = stall_cycles;

endmodule
